// File: rtl/rls_pkg.sv
//------------------------------------------------------------------------------
// Module      : rls_pkg
// Description : Shared types and default constants for run_length_scaler.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

package rls_pkg;

   localparam int RLS_CNT_W   = 5;
   localparam int RLS_SAT_MAX = 24;
   localparam int RLS_DIV_W   = 4;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_COUNT = 2'd1,
      ST_EMIT  = 2'd2
   } state_e;

   typedef enum logic [2:0] {
      OP_HOLD  = 3'd0,
      OP_LOAD1 = 3'd1,
      OP_INC   = 3'd2,
      OP_SUB   = 3'd3,
      OP_CLR   = 3'd4
   } cnt_op_e;

   // Common width that holds both the run count and the divisor.
   function automatic int max_w(input int a, input int b);
      return (a > b) ? a : b;
   endfunction

endpackage

`default_nettype wire

// File: rtl/rls_counter.sv
//------------------------------------------------------------------------------
// Module      : rls_counter
// Description : Run counter: load-1, saturating increment, subtract, clear.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module rls_counter
   import rls_pkg::*;
#(
   parameter int CNT_W   = RLS_CNT_W,
   parameter int SAT_MAX = RLS_SAT_MAX,
   parameter int DIV_W   = RLS_DIV_W
) (
   input  logic             clk,
   input  logic             reset_n,
   input  cnt_op_e          op_i,
   input  logic [DIV_W-1:0] d_i,
   output logic [CNT_W-1:0] cnt_o
);

   localparam int              CW      = max_w(CNT_W, DIV_W);
   localparam logic [CNT_W-1:0] SAT_VAL = CNT_W'(SAT_MAX);

   logic [CNT_W-1:0] cnt_q;
   logic [CNT_W-1:0] cnt_d;
   logic [CW-1:0]    diff;

   // Next count; subtraction is only requested when cnt >= d, so it never wraps.
   always_comb begin
      diff  = CW'(cnt_q) - CW'(d_i);
      cnt_d = cnt_q;
      case (op_i)
         OP_LOAD1: cnt_d = CNT_W'(1);
         OP_INC:   cnt_d = (cnt_q >= SAT_VAL) ? SAT_VAL : cnt_q + CNT_W'(1);
         OP_SUB:   cnt_d = diff[CNT_W-1:0];
         OP_CLR:   cnt_d = '0;
         default:  cnt_d = cnt_q;
      endcase
   end

   // Count register.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) cnt_q <= '0;
      else          cnt_q <= cnt_d;
   end

   assign cnt_o = cnt_q;

endmodule

`default_nettype wire

// File: rtl/run_length_scaler.sv
//------------------------------------------------------------------------------
// Module      : run_length_scaler
// Description : Measures a run of high input samples and emits floor(L/D)
//               consecutive output pulses, reporting the remainder.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module run_length_scaler
   import rls_pkg::*;
#(
   parameter int CNT_W   = RLS_CNT_W,
   parameter int SAT_MAX = RLS_SAT_MAX,
   parameter int DIV_W   = RLS_DIV_W
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic             en,
   input  logic             in,
   input  logic [DIV_W-1:0] div,
   input  logic             retrig,
   output logic             out,
   output logic             busy,
   output logic             done,
   output logic [CNT_W-1:0] rem,
   output logic             sat
);

   localparam int CW = max_w(CNT_W, DIV_W);

   state_e           state_q, state_d;
   cnt_op_e          op;
   logic [CNT_W-1:0] cnt;
   logic [DIV_W-1:0] d_q, d_d;
   logic             out_q, out_d;
   logic             busy_q, busy_d;
   logic             done_q, done_d;
   logic [CNT_W-1:0] rem_q, rem_d;
   logic             sat_q, sat_d;
   logic             cnt_ge_d;
   logic             cnt_near_sat;

   assign cnt_ge_d     = (CW'(cnt) >= CW'(d_q));
   assign cnt_near_sat = (cnt >= CNT_W'(SAT_MAX - 1));

   rls_counter #(
      .CNT_W   (CNT_W),
      .SAT_MAX (SAT_MAX),
      .DIV_W   (DIV_W)
   ) u_counter (
      .clk     (clk),
      .reset_n (reset_n),
      .op_i    (op),
      .d_i     (d_q),
      .cnt_o   (cnt)
   );

   // Next state, counter operation and output values; en=0 beats retrigger beats normal flow.
   always_comb begin
      state_d = state_q;
      op      = OP_HOLD;
      d_d     = d_q;
      out_d   = 1'b0;
      done_d  = 1'b0;
      rem_d   = rem_q;
      sat_d   = sat_q;
      case (state_q)
         ST_IDLE: begin
            if (en && in) begin
               state_d = ST_COUNT;
               op      = OP_LOAD1;
               sat_d   = 1'b0;
               rem_d   = '0;
            end else begin
               op      = OP_CLR;
            end
         end
         ST_COUNT: begin
            if (!en) begin
               state_d = ST_IDLE;
               op      = OP_CLR;
            end else if (in) begin
               op      = OP_INC;
               if (cnt_near_sat) sat_d = 1'b1;
            end else begin
               state_d = ST_EMIT;
               d_d     = (div == '0) ? DIV_W'(1) : div;
            end
         end
         ST_EMIT: begin
            if (!en) begin
               state_d = ST_IDLE;
               op      = OP_CLR;
            end else if (retrig && in) begin
               state_d = ST_COUNT;
               op      = OP_LOAD1;
               sat_d   = 1'b0;
               rem_d   = '0;
            end else if (cnt_ge_d) begin
               out_d   = 1'b1;
               op      = OP_SUB;
            end else begin
               state_d = ST_IDLE;
               op      = OP_CLR;
               done_d  = 1'b1;
               rem_d   = cnt;
            end
         end
         default: begin
            state_d = ST_IDLE;
            op      = OP_CLR;
         end
      endcase
      busy_d = (state_d != ST_IDLE);
   end

   // State, latched divisor and registered outputs.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q <= ST_IDLE;
         d_q     <= DIV_W'(1);
         out_q   <= 1'b0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
         rem_q   <= '0;
         sat_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         d_q     <= d_d;
         out_q   <= out_d;
         busy_q  <= busy_d;
         done_q  <= done_d;
         rem_q   <= rem_d;
         sat_q   <= sat_d;
      end
   end

   assign out  = out_q;
   assign busy = busy_q;
   assign done = done_q;
   assign rem  = rem_q;
   assign sat  = sat_q;

endmodule

`default_nettype wire

// File: tb/tb_run_length_scaler.sv
//------------------------------------------------------------------------------
// Module      : tb_run_length_scaler
// Description : Directed self-checking bench for run_length_scaler.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_run_length_scaler;

   logic       clk;
   logic       reset_n;
   logic       en;
   logic       in;
   logic [3:0] div;
   logic       retrig;
   logic       out;
   logic       busy;
   logic       done;
   logic [4:0] rem;
   logic       sat;

   int n_cmp;
   int n_bad;

   run_length_scaler dut (
      .clk     (clk),
      .reset_n (reset_n),
      .en      (en),
      .in      (in),
      .div     (div),
      .retrig  (retrig),
      .out     (out),
      .busy    (busy),
      .done    (done),
      .rem     (rem),
      .sat     (sat)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      int         len;
      logic [3:0] dv;
      logic [3:0] dv_after;
      int         n_exp;
      int         rem_exp;
      int         sat_exp;
   } vec_t;

   vec_t vecs [10];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0d, expected %0d", name, act, exp);
      end
   endtask

   // Drive a run of len high samples, then observe emission; k counts edges from the first low sample.
   task automatic run_burst(input int len, input logic [3:0] dv, input logic [3:0] dv_after,
                            output int n_out, output int first_out, output int done_at,
                            output int rem_v, output int sat_v, output int busy_k1);
      n_out = 0; first_out = -1; done_at = -1; rem_v = -1; sat_v = -1; busy_k1 = -1;
      @(negedge clk);
      div = dv;
      in  = 1'b1;
      repeat (len) @(negedge clk);
      in = 1'b0;
      for (int k = 1; k <= 60; k++) begin
         @(posedge clk);
         #1;
         if (k == 1) begin
            busy_k1 = int'(busy);
            div     = dv_after;
         end
         if (out) begin
            n_out++;
            if (first_out < 0) first_out = k;
         end
         if (done) begin
            done_at = k;
            rem_v   = int'(rem);
            sat_v   = int'(sat);
            break;
         end
      end
   endtask

   // Retrigger scenario: L=12, div=2, in high again for edges k=3..6.
   task automatic seq_retrig(input logic rt, input logic [15:0] exp_out, input logic [15:0] exp_done);
      logic [15:0] got_out;
      logic [15:0] got_done;
      got_out  = '0;
      got_done = '0;
      @(negedge clk);
      retrig = rt;
      div    = 4'd2;
      in     = 1'b1;
      repeat (12) @(negedge clk);
      in = 1'b0;
      for (int k = 1; k <= 15; k++) begin
         @(posedge clk);
         #1;
         got_out[k]  = out;
         got_done[k] = done;
         @(negedge clk);
         in = (k + 1 >= 3) && (k + 1 <= 6);
      end
      in = 1'b0;
      chk($sformatf("retrig%0d out pattern", rt), 32'(got_out), 32'(exp_out));
      chk($sformatf("retrig%0d done pattern", rt), 32'(got_done), 32'(exp_done));
      chk($sformatf("retrig%0d final rem", rt), 32'(rem), 32'd0);
      retrig = 1'b0;
   endtask

   initial begin
      int n_out, first_out, done_at, rem_v, sat_v, busy_k1;
      logic [15:0] m_out;
      logic [15:0] m_done;
      int done_seen;

      n_cmp = 0;
      n_bad = 0;

      vecs[0] = '{len: 10, dv: 4'd4,  dv_after: 4'd4,  n_exp: 2, rem_exp: 2, sat_exp: 0};
      vecs[1] = '{len: 3,  dv: 4'd4,  dv_after: 4'd4,  n_exp: 0, rem_exp: 3, sat_exp: 0};
      vecs[2] = '{len: 40, dv: 4'd4,  dv_after: 4'd4,  n_exp: 6, rem_exp: 0, sat_exp: 1};
      vecs[3] = '{len: 5,  dv: 4'd0,  dv_after: 4'd0,  n_exp: 5, rem_exp: 0, sat_exp: 0};
      vecs[4] = '{len: 24, dv: 4'd3,  dv_after: 4'd3,  n_exp: 8, rem_exp: 0, sat_exp: 1};
      vecs[5] = '{len: 23, dv: 4'd3,  dv_after: 4'd3,  n_exp: 7, rem_exp: 2, sat_exp: 0};
      vecs[6] = '{len: 20, dv: 4'd15, dv_after: 4'd15, n_exp: 1, rem_exp: 5, sat_exp: 0};
      vecs[7] = '{len: 1,  dv: 4'd1,  dv_after: 4'd1,  n_exp: 1, rem_exp: 0, sat_exp: 0};
      vecs[8] = '{len: 7,  dv: 4'd5,  dv_after: 4'd1,  n_exp: 1, rem_exp: 2, sat_exp: 0};
      vecs[9] = '{len: 6,  dv: 4'd7,  dv_after: 4'd2,  n_exp: 0, rem_exp: 6, sat_exp: 0};

      reset_n = 1'b0;
      en      = 1'b0;
      in      = 1'b0;
      div     = 4'd0;
      retrig  = 1'b0;
      #23;
      chk("reset out",  32'(out),  32'd0);
      chk("reset busy", 32'(busy), 32'd0);
      chk("reset done", 32'(done), 32'd0);
      chk("reset rem",  32'(rem),  32'd0);
      chk("reset sat",  32'(sat),  32'd0);
      @(negedge clk);
      reset_n = 1'b1;
      en      = 1'b1;
      @(negedge clk);

      for (int i = 0; i < 10; i++) begin
         run_burst(vecs[i].len, vecs[i].dv, vecs[i].dv_after,
                   n_out, first_out, done_at, rem_v, sat_v, busy_k1);
         chk($sformatf("v%0d out cycles", i), 32'(n_out), 32'(vecs[i].n_exp));
         chk($sformatf("v%0d out first edge", i), 32'(first_out),
             (vecs[i].n_exp > 0) ? 32'd2 : 32'hFFFF_FFFF);
         chk($sformatf("v%0d done edge", i), 32'(done_at), 32'(vecs[i].n_exp + 2));
         chk($sformatf("v%0d rem", i), 32'(rem_v), 32'(vecs[i].rem_exp));
         chk($sformatf("v%0d sat", i), 32'(sat_v), 32'(vecs[i].sat_exp));
         chk($sformatf("v%0d busy in emit", i), 32'(busy_k1), 32'd1);
         repeat (3) @(posedge clk);
         #1;
         chk($sformatf("v%0d rem hold", i), 32'(rem), 32'(vecs[i].rem_exp));
         chk($sformatf("v%0d idle busy", i), 32'(busy), 32'd0);
         chk($sformatf("v%0d done one-shot", i), 32'(done), 32'd0);
      end

      // Retrigger enabled: out at k=2, abort at k=3, new run of 4 -> out at k=8,9, done at k=10.
      m_out  = '0; m_out[2] = 1'b1; m_out[8] = 1'b1; m_out[9] = 1'b1;
      m_done = '0; m_done[10] = 1'b1;
      seq_retrig(1'b1, m_out, m_done);
      repeat (3) @(negedge clk);
      // Retrigger disabled: six outputs k=2..7, done at k=8, second run ignored.
      m_out  = 16'b0000_0000_1111_1100;
      m_done = '0; m_done[8] = 1'b1;
      seq_retrig(1'b0, m_out, m_done);
      repeat (3) @(negedge clk);

      // en dropped mid-emission: outputs clear, no done.
      div = 4'd2;
      in  = 1'b1;
      repeat (8) @(negedge clk);
      in = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      chk("en-abort out before", 32'(out), 32'd1);
      @(negedge clk);
      en = 1'b0;
      @(posedge clk);
      #1;
      chk("en-abort out", 32'(out), 32'd0);
      chk("en-abort busy", 32'(busy), 32'd0);
      done_seen = 0;
      for (int k = 0; k < 8; k++) begin
         @(posedge clk);
         #1;
         if (done) done_seen++;
      end
      chk("en-abort no done", 32'(done_seen), 32'd0);
      @(negedge clk);
      en = 1'b1;
      @(negedge clk);

      // Asynchronous reset between edges while emitting.
      div = 4'd4;
      in  = 1'b1;
      repeat (40) @(negedge clk);
      in = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      chk("pre-reset out", 32'(out), 32'd1);
      #2;
      reset_n = 1'b0;
      #1;
      chk("async reset out",  32'(out),  32'd0);
      chk("async reset busy", 32'(busy), 32'd0);
      chk("async reset done", 32'(done), 32'd0);
      chk("async reset sat",  32'(sat),  32'd0);
      @(negedge clk);
      reset_n = 1'b1;
      @(negedge clk);
      run_burst(10, 4'd4, 4'd4, n_out, first_out, done_at, rem_v, sat_v, busy_k1);
      chk("post-reset out cycles", 32'(n_out), 32'd2);
      chk("post-reset first edge", 32'(first_out), 32'd2);
      chk("post-reset done edge", 32'(done_at), 32'd4);
      chk("post-reset rem", 32'(rem_v), 32'd2);
      chk("post-reset sat", 32'(sat_v), 32'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

`default_nettype wire

// File: doc/run_length_scaler.md
RUN_LENGTH_SCALER -- requirements
Module: run_length_scaler

Interface
REQ-001 SHALL have parameter CNT_W, default 5: run counter width.
REQ-002 SHALL have parameter SAT_MAX, default 24: run-count saturation value; SAT_MAX <= 2^CNT_W-1 and SAT_MAX >= 1.
REQ-003 SHALL have parameter DIV_W, default 4: width of the divisor input.
REQ-004 SHALL have port clk  input  1  the single clock; all state updates on its rising edge.
REQ-005 SHALL have port reset_n  input  1  reset, asynchronous and active-low.
REQ-006 SHALL have port en  input  1  block enable.
REQ-007 SHALL have port in  input  1  sampled pulse input.
REQ-008 SHALL have port div  input  DIV_W  compression divisor D.
REQ-009 SHALL have port retrig  input  1  mode: 0 = ignore in during emission, 1 = a new run aborts emission.
REQ-010 SHALL have port out  output  1  scaled output pulse, registered.
REQ-011 SHALL have port busy  output  1  high when state is not IDLE, registered.
REQ-012 SHALL have port done  output  1  one-cycle pulse at emission end, registered.
REQ-013 SHALL have port rem  output  CNT_W  leftover count (L mod D) at done; holds until the next run starts.
REQ-014 SHALL have port sat  output  1  last run hit SAT_MAX; valid with done.

Function
REQ-015 SHALL implement states IDLE, COUNT and EMIT; out, busy, done, rem and sat SHALL all be registered.
REQ-016 In IDLE with en=1 and in=1, the next state SHALL be COUNT with cnt=1, sat=0 and rem=0; otherwise the block SHALL stay in IDLE with cnt=0.
REQ-017 In COUNT with in=1, cnt SHALL become min(cnt+1, SAT_MAX); sat SHALL be set when cnt reaches SAT_MAX.
REQ-018 In COUNT with in=0, the next state SHALL be EMIT, and div SHALL be latched into D_q at that edge; div=0 SHALL be latched as 1.
REQ-019 In EMIT with cnt >= D_q: out SHALL be 1 next cycle, cnt SHALL decrease by D_q, and the state SHALL remain EMIT.
REQ-020 In EMIT with cnt < D_q: out SHALL be 0, done SHALL be 1 for one cycle, rem SHALL equal cnt, and the next state SHALL be IDLE with cnt=0.
REQ-021 Timing: for a run of L consecutive high samples, out SHALL be high for exactly floor(min(L,SAT_MAX)/D) consecutive cycles.
- out SHALL rise 2 edges after the first low sample.
- done SHALL assert the cycle after out falls, or 2 edges after the first low sample if the count is 0.
REQ-022 div changes outside the latching edge SHALL have no effect on the run in progress.
REQ-023 In EMIT with retrig=0, in SHALL be ignored.
REQ-024 In EMIT with retrig=1 and in=1, out SHALL be 0 next cycle and the next state SHALL be COUNT with cnt=1; done SHALL NOT pulse for the aborted run.
REQ-025 en=0 in COUNT or EMIT SHALL force the next state to IDLE with cnt=0 and out=0; done SHALL NOT pulse.
REQ-026 Simultaneous events SHALL resolve with priority en=0, then retrigger abort, then normal transition.
REQ-027 Unreachable state encodings SHALL return to IDLE on the next edge.

Reset
REQ-028 reset_n=0 SHALL asynchronously force state=IDLE, cnt=0, D_q=1, out=0, busy=0, done=0, rem=0 and sat=0, including mid-COUNT or mid-EMIT.
REQ-029 After reset release, the first run SHALL start no earlier than the first rising edge that samples reset_n=1.

Structure
REQ-030 The state enum and the default parameter constants SHALL reside in shared package rls_pkg.
REQ-031 One sub-module, rls_counter, SHALL implement the counter operations.
- Operations: load-1, saturating increment to SAT_MAX, subtract D_q, clear.
- The FSM and output registers SHALL stay in run_length_scaler.

Verification
REQ-032 Directed: defaults, div=4, en=1, retrig=0, L=10 -> out high 2 cycles starting 2 edges after first low sample; done next; rem=2; sat=0.
REQ-033 Directed: div=4, L=3 -> out never high; done 2 edges after first low sample; rem=3.
REQ-034 Directed: div=4, L=40 -> cnt saturates at 24; out high 6 cycles; rem=0; sat=1.
REQ-035 Directed: div=0, L=5 -> D treated as 1; out high 5 cycles; rem=0.
REQ-036 Directed: retrig=1, div=2, L=12, in=1 again after out's first high cycle -> out=0 next cycle; no done; new run L=4 -> out high 2 cycles; rem=0. The same stimulus with retrig=0 -> 6 out cycles, second run ignored.
REQ-037 Directed: reset_n=0 mid-EMIT (asynchronous, between edges) -> out, busy and done go 0 immediately; next run behaves per REQ-032.
